// File: rtl/dual_buffer_reader.sv
// dual_buffer_reader: drain side of the ping-pong packet buffer.
// Takes "half full" announcements from the writer. Reads each packet of that
// half from the RAM and sends it as AXI-Stream beats. Then releases the half
// back to the writer.
// Optional build macro DUAL_BUFFER_READER_PERF_EN adds two outputs,
// perf_pkt_cnt and perf_stall_cnt, which are free-running counters.
module dual_buffer_reader #(
  parameter  int DATA_WIDTH             = 16000,
  parameter  int NUM_PACKETS_PER_BUFFER = 8,
  parameter  int AXIS_WIDTH             = 512,
  localparam int ADDR_WIDTH             = $clog2(NUM_PACKETS_PER_BUFFER)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_valid,
  output logic                  buf_ready,
  input  logic                  buf_idx,
  input  logic [ADDR_WIDTH-1:0] buf_count,
  output logic                  buf_done,
  output logic                  buf_done_idx,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [AXIS_WIDTH-1:0] axis_tdata,
  output logic                  axis_tvalid,
  input  logic                  axis_tready,
  output logic                  axis_tlast
`ifdef DUAL_BUFFER_READER_PERF_EN
  ,
  output logic [31:0]           perf_pkt_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int HALF  = NUM_PACKETS_PER_BUFFER / 2;
  localparam int BEATS = (DATA_WIDTH + AXIS_WIDTH - 1) / AXIS_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PADW  = BEATS * AXIS_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_STREAM  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  // announcement latched at accept time
  typedef struct packed {
    logic                  idx;
    logic [ADDR_WIDTH-1:0] count;
  } ann_t;

  logic [1:0]            state;
  ann_t                  ann;
  logic [ADDR_WIDTH-1:0] pkt_cnt;
  logic [BW-1:0]         beat_cnt;
  logic [BW-1:0]         beat_nxt;
  logic [1:0]            vld_pipe;  // RAM read latency, one bit per cycle
  logic                  rdy;
  logic [PADW-1:0]       rd_pad;    // RAM word zero-extended to whole beats
  logic                  hs;
  logic                  last_beat;
  logic                  last_pkt;
  logic [ADDR_WIDTH-1:0] cnt_clamp;

  assign rd_pad    = PADW'(rd_data);
  assign hs        = (state == S_STREAM) && axis_tready;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign beat_nxt  = beat_cnt + 1'b1;
  assign last_pkt  = ((pkt_cnt + 1'b1) == ann.count);
  assign cnt_clamp = (buf_count > ADDR_WIDTH'(HALF)) ? ADDR_WIDTH'(HALF) : buf_count;

  assign buf_ready   = rdy;
  assign axis_tvalid = (state == S_STREAM);
  assign axis_tlast  = axis_tvalid && last_beat;

  // Main controller. It accepts a half, fetches each packet and serializes
  // it into beats. The packet data comes straight from rd_data; rd_addr is
  // held for the whole packet, so no packet-wide buffer is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ann          <= '0;
      pkt_cnt      <= '0;
      beat_cnt     <= '0;
      vld_pipe     <= '0;
      rdy          <= 1'b0;
      rd_addr      <= '0;
      axis_tdata   <= '0;
      buf_done     <= 1'b0;
      buf_done_idx <= 1'b0;
    end else begin
      buf_done     <= 1'b0;
      buf_done_idx <= 1'b0;
      case (state)
        S_IDLE: begin
          rdy <= 1'b1;
          if (buf_valid && rdy) begin
            ann.idx   <= buf_idx;
            ann.count <= cnt_clamp;
            rd_addr   <= buf_idx ? ADDR_WIDTH'(HALF) : '0;
            pkt_cnt   <= '0;
            rdy       <= 1'b0;
            if (cnt_clamp == '0) begin
              state        <= S_RELEASE;
              buf_done     <= 1'b1;
              buf_done_idx <= buf_idx;
            end else begin
              state    <= S_FETCH;
              vld_pipe <= 2'b01;
            end
          end
        end
        S_FETCH: begin
          vld_pipe <= {vld_pipe[0], 1'b0};
          if (vld_pipe[1]) begin
            axis_tdata <= rd_pad[0 +: AXIS_WIDTH];
            beat_cnt   <= '0;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (hs) begin
            if (!last_beat) begin
              beat_cnt   <= beat_nxt;
              axis_tdata <= rd_pad[int'(beat_nxt) * AXIS_WIDTH +: AXIS_WIDTH];
            end else if (!last_pkt) begin
              pkt_cnt  <= pkt_cnt + 1'b1;
              rd_addr  <= rd_addr + 1'b1;
              vld_pipe <= 2'b01;
              state    <= S_FETCH;
            end else begin
              state        <= S_RELEASE;
              buf_done     <= 1'b1;
              buf_done_idx <= ann.idx;
            end
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
          rdy   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DUAL_BUFFER_READER_PERF_EN
  // Free-running counters: packets completed, and sink back-pressure cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_pkt_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hs && last_beat)
        perf_pkt_cnt <= perf_pkt_cnt + 32'd1;
      if (axis_tvalid && !axis_tready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_buffer_reader.sv
// Testbench for dual_buffer_reader. A RAM model holds random packets. A
// negedge monitor records every beat handshake and every buf_done pulse.
// Each test task compares what was recorded against a bit-level reference
// built from the RAM contents.
module tb_dual_buffer_reader;
  localparam int DW    = 16000;
  localparam int NP    = 8;
  localparam int AXW   = 512;
  localparam int ADW   = 3;
  localparam int BEATS = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           buf_valid;
  logic           buf_ready;
  logic           buf_idx;
  logic [ADW-1:0] buf_count;
  logic           buf_done;
  logic           buf_done_idx;
  logic [ADW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic [AXW-1:0] axis_tdata;
  logic           axis_tvalid;
  logic           axis_tready;
  logic           axis_tlast;
`ifdef DUAL_BUFFER_READER_PERF_EN
  logic [31:0]    perf_pkt_cnt;
  logic [31:0]    perf_stall_cnt;
`endif

  dual_buffer_reader dut (
    .clk(clk), .rst(rst),
    .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_idx(buf_idx),
    .buf_count(buf_count), .buf_done(buf_done), .buf_done_idx(buf_done_idx),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready), .axis_tlast(axis_tlast)
`ifdef DUAL_BUFFER_READER_PERF_EN
    , .perf_pkt_cnt(perf_pkt_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NP];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  bit tready_rand = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor state
  logic [AXW-1:0] bq_data[$];
  logic           bq_last[$];
  int             bq_addr[$];
  int             bq_cyc[$];
  int             done_idx_q[$];
  int             done_cyc_q[$];
  int             tv_samples, stall_bad, obs_stalls, obs_pkts;
  logic           prev_stall;
  logic [AXW-1:0] prev_data;
  logic           prev_last;

  initial begin
    tv_samples = 0; stall_bad = 0; obs_stalls = 0; obs_pkts = 0; prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0; obs_stalls = 0; obs_pkts = 0;
      end else begin
        if (prev_stall && (!axis_tvalid || axis_tdata !== prev_data || axis_tlast !== prev_last))
          stall_bad++;
        prev_stall = axis_tvalid && !axis_tready;
        prev_data  = axis_tdata;
        prev_last  = axis_tlast;
        if (axis_tvalid) tv_samples++;
        if (axis_tvalid && !axis_tready) obs_stalls++;
        if (axis_tvalid && axis_tready) begin
          bq_data.push_back(axis_tdata);
          bq_last.push_back(axis_tlast);
          bq_addr.push_back(int'(rd_addr));
          bq_cyc.push_back(cyc);
          if (axis_tlast) obs_pkts++;
        end
        if (buf_done) begin
          done_idx_q.push_back(int'(buf_done_idx));
          done_cyc_q.push_back(cyc);
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  // Reference beat: bit j of beat b is packet bit b*AXW+j, or 0 past the packet end.
  function automatic logic [AXW-1:0] exp_beat(int a, int b);
    logic [AXW-1:0] r;
    for (int j = 0; j < AXW; j++) begin
      int g;
      g = b * AXW + j;
      r[j] = (g < DW) ? mem[a][g] : 1'b0;
    end
    return r;
  endfunction

  // Counts deviations of the recorded stream from npk packets starting at address base.
  function automatic int sb_errors(int base, int npk);
    int e;
    e = 0;
    if (bq_data.size() != npk * BEATS) return 100000;
    for (int p = 0; p < npk; p++)
      for (int b = 0; b < BEATS; b++) begin
        int k;
        k = p * BEATS + b;
        if (bq_data[k] !== exp_beat(base + p, b)) e++;
        if (bq_addr[k] != base + p) e++;
        if (bq_last[k] !== (b == BEATS - 1)) e++;
      end
    return e;
  endfunction

  task automatic fill_mem();
    for (int a = 0; a < NP; a++)
      for (int w = 0; w < DW / 32; w++)
        mem[a][w*32 +: 32] = $urandom;
  endtask

  task automatic clear_mon();
    bq_data.delete(); bq_last.delete(); bq_addr.delete(); bq_cyc.delete();
    done_idx_q.delete(); done_cyc_q.delete();
    tv_samples = 0; stall_bad = 0;
  endtask

  task automatic announce(input logic idx, input int cnt, output int acc_c, output bit ok);
    @(posedge clk); #1;
    buf_idx = idx; buf_count = cnt[ADW-1:0]; buf_valid = 1'b1;
    ok = 1'b0; acc_c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (buf_ready) begin acc_c = cyc; ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    buf_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cyc_q.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; buf_valid = 1'b0; buf_idx = 1'b0; buf_count = '0; axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (buf_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", buf_ready); else n_pass++;
    n_chk++; if (axis_tvalid !== 1'b0 || axis_tlast !== 1'b0) $display("FAIL reset_tvalid: got %b/%b exp 0/0", axis_tvalid, axis_tlast); else n_pass++;
    n_chk++; if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr); else n_pass++;
    n_chk++; if (axis_tdata !== '0) $display("FAIL reset_tdata: got nonzero exp 0"); else n_pass++;
    n_chk++; if (buf_done !== 1'b0 || buf_done_idx !== 1'b0) $display("FAIL reset_done: got %b/%b exp 0/0", buf_done, buf_done_idx); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (buf_ready !== 1'b1) $display("FAIL after_reset_ready: got %b exp 1", buf_ready); else n_pass++;
  endtask

  task automatic test_basic();
    int acc; bit ok; bit dok;
    fill_mem(); clear_mon();
    announce(1'b1, 2, acc, ok);
    wait_done(400, dok);
    n_chk++; if (!(ok && dok)) $display("FAIL basic_handshake: accepted %b done %b exp 1/1", ok, dok); else n_pass++;
    @(negedge clk);
    n_chk++; if (buf_ready !== 1'b1) $display("FAIL basic_ready_after_done: got %b exp 1", buf_ready); else n_pass++;
    n_chk++; if (sb_errors(4, 2) != 0) $display("FAIL basic_stream: %0d errors in %0d beats exp 0 errors in 64", sb_errors(4, 2), bq_data.size()); else n_pass++;
    if (bq_cyc.size() == 64 && done_cyc_q.size() > 0) begin
      n_chk++; if (bq_cyc[0] != acc + 3) $display("FAIL basic_first_tvalid: got cycle %0d exp %0d", bq_cyc[0], acc + 3); else n_pass++;
      n_chk++; if (bq_cyc[32] != bq_cyc[31] + 3) $display("FAIL basic_pkt_gap: got cycle %0d exp %0d", bq_cyc[32], bq_cyc[31] + 3); else n_pass++;
      n_chk++; if (done_cyc_q[0] != bq_cyc[63] + 1) $display("FAIL basic_done_time: got cycle %0d exp %0d", done_cyc_q[0], bq_cyc[63] + 1); else n_pass++;
      n_chk++; if (done_idx_q[0] != 1) $display("FAIL basic_done_idx: got %0d exp 1", done_idx_q[0]); else n_pass++;
    end
    n_chk++; if (done_cyc_q.size() != 1) $display("FAIL basic_done_count: got %0d exp 1", done_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_random_ready();
    int acc; bit ok; bit dok;
    fill_mem(); clear_mon();
    tready_rand = 1'b1;
    announce(1'b0, 4, acc, ok);
    wait_done(3000, dok);
    tready_rand = 1'b0;
    @(negedge clk);
    n_chk++; if (!(ok && dok)) $display("FAIL rand_handshake: accepted %b done %b exp 1/1", ok, dok); else n_pass++;
    n_chk++; if (sb_errors(0, 4) != 0) $display("FAIL rand_stream: %0d errors in %0d beats exp 0 errors in 128", sb_errors(0, 4), bq_data.size()); else n_pass++;
    n_chk++; if (stall_bad != 0) $display("FAIL rand_stall_stable: got %0d changes exp 0", stall_bad); else n_pass++;
    n_chk++; if (done_idx_q.size() != 1 || done_idx_q[0] != 0) $display("FAIL rand_done: got %0d pulses exp 1 with idx 0", done_idx_q.size()); else n_pass++;
`ifdef DUAL_BUFFER_READER_PERF_EN
    n_chk++; if (perf_stall_cnt != 32'(obs_stalls)) $display("FAIL perf_stall: got %0d exp %0d", perf_stall_cnt, obs_stalls); else n_pass++;
    n_chk++; if (perf_pkt_cnt != 32'(obs_pkts)) $display("FAIL perf_pkt: got %0d exp %0d", perf_pkt_cnt, obs_pkts); else n_pass++;
`endif
  endtask

  task automatic test_zero_count();
    int acc; bit ok; bit dok;
    clear_mon();
    announce(1'b0, 0, acc, ok);
    wait_done(20, dok);
    repeat (3) @(negedge clk);
    n_chk++; if (!(ok && dok)) $display("FAIL zero_handshake: accepted %b done %b exp 1/1", ok, dok); else n_pass++;
    n_chk++; if (tv_samples != 0) $display("FAIL zero_tvalid: got %0d valid cycles exp 0", tv_samples); else n_pass++;
    if (done_cyc_q.size() > 0) begin
      n_chk++; if (done_cyc_q[0] != acc + 1) $display("FAIL zero_done_time: got cycle %0d exp %0d", done_cyc_q[0], acc + 1); else n_pass++;
      n_chk++; if (done_idx_q[0] != 0) $display("FAIL zero_done_idx: got %0d exp 0", done_idx_q[0]); else n_pass++;
    end
  endtask

  task automatic test_clamp();
    int acc; bit ok; bit dok;
    fill_mem(); clear_mon();
    announce(1'b0, 7, acc, ok);
    wait_done(1000, dok);
    repeat (3) @(negedge clk);
    n_chk++; if (!(ok && dok)) $display("FAIL clamp_handshake: accepted %b done %b exp 1/1", ok, dok); else n_pass++;
    n_chk++; if (bq_data.size() != 4 * BEATS) $display("FAIL clamp_beats: got %0d exp %0d", bq_data.size(), 4 * BEATS); else n_pass++;
    n_chk++; if (sb_errors(0, 4) != 0) $display("FAIL clamp_stream: got %0d errors exp 0", sb_errors(0, 4)); else n_pass++;
    n_chk++; if (done_cyc_q.size() != 1) $display("FAIL clamp_done_count: got %0d exp 1", done_cyc_q.size()); else n_pass++;
  endtask

  task automatic test_padding();
    int acc; bit ok; bit dok;
    logic [AXW-1:0] exp_pad;
    logic [AXW-1:0] exp_ones;
    exp_pad = '0; exp_pad[127:0] = '1;
    exp_ones = '1;
    mem[0] = '1; clear_mon();
    announce(1'b0, 1, acc, ok);
    wait_done(200, dok);
    n_chk++; if (!(ok && dok)) $display("FAIL pad_handshake: accepted %b done %b exp 1/1", ok, dok); else n_pass++;
    if (bq_data.size() == BEATS) begin
      n_chk++; if (bq_data[31] !== exp_pad) $display("FAIL pad_last_beat: got %h exp %h", bq_data[31][255:0], exp_pad[255:0]); else n_pass++;
      n_chk++; if (bq_data[0] !== exp_ones) $display("FAIL pad_first_beat: got %h exp all ones", bq_data[0][63:0]); else n_pass++;
    end
    n_chk++; if (sb_errors(0, 1) != 0) $display("FAIL pad_stream: got %0d errors exp 0", sb_errors(0, 1)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc; bit ok; bit dok; bit hit;
    fill_mem(); clear_mon();
    announce(1'b1, 2, acc, ok);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (bq_data.size() >= BEATS + 10) begin hit = 1'b1; break; end
    end
    n_chk++; if (!(ok && hit)) $display("FAIL midrst_reach_beat: accepted %b reached %b exp 1/1", ok, hit); else n_pass++;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_chk++; if (axis_tvalid !== 1'b0 || axis_tlast !== 1'b0 || buf_ready !== 1'b0) $display("FAIL midrst_ctrl: got tvalid %b tlast %b ready %b exp 0/0/0", axis_tvalid, axis_tlast, buf_ready); else n_pass++;
    n_chk++; if (axis_tdata !== '0 || rd_addr !== '0) $display("FAIL midrst_data: got addr %0d exp 0 and zero tdata", rd_addr); else n_pass++;
    n_chk++; if (buf_done !== 1'b0) $display("FAIL midrst_done: got %b exp 0", buf_done); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (done_cyc_q.size() != 0) $display("FAIL midrst_no_done: got %0d pulses exp 0", done_cyc_q.size()); else n_pass++;
    n_chk++; if (buf_ready !== 1'b1) $display("FAIL midrst_ready: got %b exp 1", buf_ready); else n_pass++;
    clear_mon();
    announce(1'b0, 1, acc, ok);
    wait_done(200, dok);
    n_chk++; if (!(ok && dok)) $display("FAIL midrst_restart: accepted %b done %b exp 1/1", ok, dok); else n_pass++;
    n_chk++; if (sb_errors(0, 1) != 0) $display("FAIL midrst_stream: got %0d errors exp 0", sb_errors(0, 1)); else n_pass++;
  endtask

  initial begin
    axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_random_ready();
    test_zero_count();
    test_clamp();
    test_padding();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dual_buffer_reader.md
# dual_buffer_reader

Drain-side controller for the ping-pong packet buffer. It accepts "half-buffer full" notifications from the writer and issues registered read addresses to the buffer RAM. Each DATA_WIDTH-bit packet is serialized into AXIS_WIDTH-bit AXI-Stream beats toward the host link, and the half is released back to the writer once drained.

## Interface
- DATA_WIDTH, 16000, packet width in bits (equals RAM word width)
- NUM_PACKETS_PER_BUFFER, 8, total RAM entries; ping half = [0, N/2), pong half = [N/2, N)
- AXIS_WIDTH, 512, stream beat width; BEATS = ceil(DATA_WIDTH/AXIS_WIDTH)
- ADDR_WIDTH (local), $clog2(NUM_PACKETS_PER_BUFFER)

Ports:
- clk  in  1  sole clock
- rst  in  1  reset; asynchronous, active-high
- buf_valid  in  1  writer announces a filled half; held until accepted
- buf_ready  out  1  reader idle, can accept
- buf_idx  in  1  half being announced (0 ping, 1 pong)
- buf_count  in  ADDR_WIDTH  packets in that half
- buf_done  out  1  one-cycle pulse: half released
- buf_done_idx  out  1  half released by buf_done
- rd_addr  out  ADDR_WIDTH  RAM read address, registered
- rd_data  in  DATA_WIDTH  RAM read data, valid one clk after rd_addr sampled
- axis_tdata  out  AXIS_WIDTH  beat payload, registered
- axis_tvalid  out  1  beat valid
- axis_tready  in  1  sink accepts beat
- axis_tlast  out  1  last beat of a packet

## Operation
- States: IDLE, FETCH, STREAM, RELEASE.
- IDLE: buf_ready=1.
  - On buf_valid: latch idx and count.
  - Count is clamped to N/2 when above N/2.
  - Set rd_addr = idx*(N/2), pkt_cnt=0.
  - Go to FETCH; if count==0, go directly to RELEASE.
- FETCH: two cycles (RAM latency). Then load beat 0 into axis_tdata, set beat_cnt=0, go to STREAM.
- STREAM: axis_tvalid=1. axis_tlast=1 iff beat_cnt==BEATS-1. On handshake (tvalid&&tready):
  - Not last beat: load beat beat_cnt+1 from rd_data into axis_tdata the same edge. No bubble within a packet.
  - Last beat, pkt_cnt<count-1: pkt_cnt++, rd_addr++, go to FETCH.
  - Last beat, final packet: go to RELEASE.
- RELEASE: buf_done=1 and buf_done_idx=latched idx for exactly one cycle, then IDLE.
- Beat i = rd_data[i*AXIS_WIDTH +: AXIS_WIDTH]. Bits beyond DATA_WIDTH on the final beat are driven 0.
- rd_addr is held constant for a whole packet. rd_data is used directly as the beat source, with no packet-wide holding register. The writer never writes a half between announcing it and seeing buf_done.
- buf_valid while buf_ready=0 is ignored. The writer keeps it asserted.

## Timing
- Reset values: buf_ready=0 during reset, 1 the first cycle after reset. All other outputs are 0 (rd_addr=0, axis_tdata=0, buf_done=0, buf_done_idx=0). State is IDLE.
- Acceptance at edge k: rd_addr valid after k; RAM samples at k+1; beat 0 with axis_tvalid=1 after edge k+2.
- Between packets of the same half: 2-cycle tvalid gap after the last-beat handshake.
- Final handshake at edge m: buf_done high in cycle m..m+1; buf_ready high from edge m+1 onward.
- axis_tdata/axis_tlast are stable while tvalid&&!tready (AXI-Stream rule). tvalid never drops without a handshake.
- Reset asserted mid-operation: all outputs go to reset values immediately. The partial packet is abandoned and no buf_done is issued.

## Configuration
- DUAL_BUFFER_READER_PERF_EN defined adds two outputs:
  - perf_pkt_cnt[31:0]: packets fully streamed.
  - perf_stall_cnt[31:0]: cycles with tvalid&&!tready.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

## Test plan
- Defaults, buf_idx=1, buf_count=2, tready=1:
  - rd_addr=4 then 5; 64 beats; tlast on beats 31 and 63.
  - buf_done=1 with buf_done_idx=1 the cycle after beat 63; first tvalid 2 cycles after acceptance.
- Random tready (50%) over buf_count=4: every beat emitted once, in order; tdata/tlast unchanged across stalls. With PERF_EN, perf_stall_cnt equals the observed stall cycles.
- buf_count=0, buf_idx=0: no tvalid; buf_done with idx 0 one cycle after acceptance.
- buf_count=7: clamped to 4 packets (rd_addr 0..3).
- Padding: rd_data all ones → beat 31 has bits [127:0]=1 and [511:128]=0.
- Reset asserted at beat 10 of packet 1: outputs zero, no buf_done. Next announcement (idx 0, count 1) streams from beat 0 at rd_addr=0.
